// File: rtl/seq_scan_controller.sv
// seq_scan_controller
//   Serial pattern-detection scan controller. When start is accepted in IDLE,
//   the word, pattern and overlap mode are latched. The word is then shifted
//   out MSB first, one bit per clock. A window of the last PAT_W bits is
//   compared against the pattern, and hits are counted in either overlapping
//   or non-overlapping mode. busy and done form the handshake with the host.
//
// Ports
//   clk          in   clock, all logic on posedge
//   rst          in   synchronous reset, active-high (takes priority over start)
//   start        in   scan request, sampled only in IDLE
//   data_in      in   [DATA_W-1:0] word to scan, latched on accept
//   pattern      in   [PAT_W-1:0]  pattern, latched on accept, MSB compared first
//   overlap      in   1 = overlapping matches, 0 = non-overlapping; latched on accept
//   busy         out  high during the DATA_W shift cycles
//   done         out  one-cycle pulse after the last shift cycle
//   ser_bit      out  bit consumed this cycle (0 when not shifting)
//   match_pulse  out  registered, one cycle high per detected match
//   match_count  out  [CNT_W-1:0] saturating match count, held until next accept
module seq_scan_controller #(
    parameter int DATA_W = 16,
    parameter int PAT_W  = 5,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    input  logic [PAT_W-1:0]  pattern,
    input  logic              overlap,
    output logic              busy,
    output logic              done,
    output logic              ser_bit,
    output logic              match_pulse,
    output logic [CNT_W-1:0]  match_count
);

    localparam int BC_W   = $clog2(DATA_W + 1);
    localparam int FILL_W = $clog2(PAT_W + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [PAT_W-1:0]    pat_q, pat_d;
    logic                ovl_q, ovl_d;
    logic [PAT_W-2:0]    hist_q, hist_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [BC_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                pulse_q, pulse_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [PAT_W-1:0]    window;
    logic [FILL_W-1:0]   fill_inc;
    logic                hit;

    // The MSB of the shift register is always the bit being consumed.
    assign window   = {hist_q, shreg_q[DATA_W-1]};
    assign fill_inc = (fill_q == FILL_W'(PAT_W)) ? fill_q : fill_q + FILL_W'(1);
    assign hit      = (state_q == S_SHIFT) && (fill_inc == FILL_W'(PAT_W)) && (window == pat_q);

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        pat_d     = pat_q;
        ovl_d     = ovl_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        bit_cnt_d = bit_cnt_q;
        pulse_d   = 1'b0;
        cnt_d     = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shreg_d   = data_in;
                    pat_d     = pattern;
                    ovl_d     = overlap;
                    cnt_d     = '0;
                    hist_d    = '0;
                    fill_d    = '0;
                    bit_cnt_d = '0;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                shreg_d   = shreg_q << 1;
                hist_d    = window[PAT_W-2:0];
                // Non-overlapping mode restarts the window fill after a hit so
                // bits of a matched pattern are never reused.
                fill_d    = (hit && !ovl_q) ? '0 : fill_inc;
                pulse_d   = hit;
                if (hit && (cnt_q != {CNT_W{1'b1}})) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                bit_cnt_d = bit_cnt_q + BC_W'(1);
                if (bit_cnt_q == BC_W'(DATA_W - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            shreg_q   <= '0;
            pat_q     <= '0;
            ovl_q     <= 1'b0;
            hist_q    <= '0;
            fill_q    <= '0;
            bit_cnt_q <= '0;
            pulse_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            pat_q     <= pat_d;
            ovl_q     <= ovl_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            bit_cnt_q <= bit_cnt_d;
            pulse_q   <= pulse_d;
            cnt_q     <= cnt_d;
        end
    end

    assign busy        = (state_q == S_SHIFT);
    assign done        = (state_q == S_DONE);
    assign ser_bit     = busy & shreg_q[DATA_W-1];
    assign match_pulse = pulse_q;
    assign match_count = cnt_q;

endmodule
